i2c_reg_sequencer: RTL and testbench

Command-level controller that sequences the byte-oriented I2C master for register accesses. It accepts one register write or read command from the system side and drives the master's `ena`/`addr`/`rw`/`data_wr` handshake beat by beat. For reads it issues the register-pointer write, then a repeated-start read of 1–4 bytes. It returns the read data and an error flag in a single response pulse.

---
 rtl/i2c_seq_pkg.sv | 19 +
 rtl/i2c_busy_sync.sv | 30 +++
 rtl/i2c_reg_sequencer.sv | 162 ++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared state encoding, constants and beat helpers for i2c_reg_sequencer.
package i2c_seq_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_RESP} state_t;

    localparam logic I2C_SEQ_W      = 1'b0;
    localparam logic I2C_SEQ_R      = 1'b1;
    localparam int   I2C_SEQ_MAX_RD = 4;
    localparam int   BEAT_W         = 3;

    typedef logic [BEAT_W-1:0] beat_t;

    // Index of the final beat: one data byte after the pointer for writes,
    // rlen+1 read bytes after the pointer for reads.
    function automatic beat_t last_beat(input logic rw, input logic [1:0] rlen);
        return rw ? beat_t'(rlen) + beat_t'(1) : beat_t'(1);
    endfunction

endpackage

// File: rtl/i2c_busy_sync.sv
// i2c_busy_sync: two-flop synchroniser for the master busy flag with rise/fall pulses.
module i2c_busy_sync (
    input  logic clk,
    input  logic reset,
    input  logic busy_in,
    output logic busy,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Two synchronising stages plus one history stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= busy_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign busy = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: sequences register write/read commands onto a byte-level I2C master.
// Optional busy watchdog is compiled in when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rw,
    input  logic [6:0]                  cmd_dev,
    input  logic [7:0]                  cmd_reg,
    input  logic [7:0]                  cmd_wdata,
    input  logic [1:0]                  cmd_rlen,
    output logic                        rsp_valid,
    output logic [8*I2C_SEQ_MAX_RD-1:0] rsp_rdata,
    output logic                        rsp_err,
    output logic                        mst_ena,
    output logic [6:0]                  mst_addr,
    output logic                        mst_rw,
    output logic [7:0]                  mst_data_wr,
    input  logic                        mst_busy,
    input  logic [7:0]                  mst_data_rd,
    input  logic                        mst_ack_error
);

    state_t      state;
    beat_t       beat;
    beat_t       last;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [1:0]  rlen_q;
    logic        err;
    logic        seen_low;
    logic        busy_s;
    logic        rise;
    logic        fall;
    logic        timeout;
    logic [1:0]  rd_idx;

    i2c_busy_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .busy_in (mst_busy),
        .busy    (busy_s),
        .rise    (rise),
        .fall    (fall)
    );

    assign last    = last_beat(rw_q, rlen_q);
    // A fall while presenting beat n ends beat n-1, which carries read byte n-2.
    assign rd_idx  = 2'(beat - beat_t'(2));
    assign rsp_err = err;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog;

    // Watchdog restarts on every synchronised busy edge and runs only while a command is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdog <= '0;
        else if (state == ST_IDLE || rise || fall)
            wdog <= '0;
        else if (state != ST_RESP)
            wdog <= wdog + 16'd1;
    end

    assign timeout = (state == ST_RUN || state == ST_DRAIN) && !(rise || fall) && wdog == WDOG_LIM;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Command FSM: accepts a command, walks the beat list on busy rises, drains, then responds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            beat        <= '0;
            rw_q        <= I2C_SEQ_W;
            wdata_q     <= '0;
            rlen_q      <= '0;
            err         <= 1'b0;
            seen_low    <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            mst_ena     <= 1'b0;
            mst_addr    <= '0;
            mst_rw      <= 1'b0;
            mst_data_wr <= '0;
        end else begin
            if (state != ST_IDLE && mst_ack_error)
                err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state       <= ST_RUN;
                        cmd_ready   <= 1'b0;
                        rw_q        <= cmd_rw;
                        wdata_q     <= cmd_wdata;
                        rlen_q      <= cmd_rlen;
                        beat        <= '0;
                        err         <= 1'b0;
                        rsp_rdata   <= '0;
                        mst_ena     <= 1'b1;
                        mst_addr    <= cmd_dev;
                        mst_rw      <= I2C_SEQ_W;
                        mst_data_wr <= cmd_reg;
                    end
                end
                ST_RUN: begin
                    if (timeout) begin
                        mst_ena   <= 1'b0;
                        err       <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        if (fall && rw_q && beat >= beat_t'(2))
                            rsp_rdata[{rd_idx, 3'b000} +: 8] <= mst_data_rd;
                        if (rise) begin
                            if (beat == last) begin
                                mst_ena  <= 1'b0;
                                seen_low <= 1'b0;
                                state    <= ST_DRAIN;
                            end else begin
                                beat        <= beat + beat_t'(1);
                                mst_rw      <= rw_q;
                                mst_data_wr <= rw_q ? 8'h00 : wdata_q;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (timeout) begin
                        err       <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (busy_s) begin
                        seen_low <= 1'b0;
                    end else if (seen_low) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        seen_low <= 1'b1;
                        if (rw_q)
                            rsp_rdata[{rlen_q, 3'b000} +: 8] <= mst_data_rd;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: randomized scoreboard bench driving i2c_reg_sequencer against a behavioural I2C master.
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        logic       nack;
    } beat_s;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_s;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_rw = 1'b0;
    logic [6:0]  cmd_dev = '0;
    logic [7:0]  cmd_reg = '0;
    logic [7:0]  cmd_wdata = '0;
    logic [1:0]  cmd_rlen = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mst_ena;
    logic [6:0]  mst_addr;
    logic        mst_rw;
    logic [7:0]  mst_data_wr;
    logic        mst_busy;
    logic [7:0]  mst_data_rd;
    logic        mst_ack_error;

    int checks = 0;
    int failures = 0;
    int outstanding = 0;
    int beats_seen = 0;

    beat_s      exp_beat[$];
    rsp_s       exp_rsp[$];
    logic [7:0] slave_q[$];
    logic       prev_valid = 1'b0;
    rsp_s       mon_r;

    always #5 clk = ~clk;

    i2c_reg_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_dev       (cmd_dev),
        .cmd_reg       (cmd_reg),
        .cmd_wdata     (cmd_wdata),
        .cmd_rlen      (cmd_rlen),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mst_ena       (mst_ena),
        .mst_addr      (mst_addr),
        .mst_rw        (mst_rw),
        .mst_data_wr   (mst_data_wr),
        .mst_busy      (mst_busy),
        .mst_data_rd   (mst_data_rd),
        .mst_ack_error (mst_ack_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Issue one command; expectations are queued before the accepting edge.
    task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                         input logic [1:0] rlen, input logic nk, input logic [31:0] bytes);
        beat_s b;
        rsp_s  r;
        int    n;
        cmd_rw    = rw;
        cmd_dev   = dev;
        cmd_reg   = rg;
        cmd_wdata = wd;
        cmd_rlen  = rlen;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 5000);
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: cmd_ready still %b after %0d cycles, required 1", cmd_ready, n);
            finish_run();
        end
        r.rdata = '0;
        r.err   = nk;
        b.addr  = dev;
        b.rw    = 1'b0;
        b.data  = rg;
        b.nack  = nk;
        exp_beat.push_back(b);
        b.nack  = 1'b0;
        if (!rw) begin
            b.data = wd;
            exp_beat.push_back(b);
        end else begin
            for (int k = 0; k <= int'(rlen); k++) begin
                b.rw   = 1'b1;
                b.data = '0;
                exp_beat.push_back(b);
                slave_q.push_back(bytes[8*k +: 8]);
                r.rdata[8*k +: 8] = bytes[8*k +: 8];
            end
        end
        exp_rsp.push_back(r);
        @(posedge clk);
        #1;
        outstanding++;
    endtask

    // Behavioural master: latches a beat when ena is seen, holds busy for a while,
    // pulses ack_error on a NACKed beat and presents read data as busy falls.
    initial begin
        beat_s b;
        logic  is_rd;
        logic  nk;
        int    hi;
        mst_busy      = 1'b0;
        mst_data_rd   = '0;
        mst_ack_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mst_ena && !reset) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                if (mst_ena) begin
                    nk = 1'b0;
                    if (exp_beat.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL beat_unexpected: addr %h rw %b data %h with no beat expected",
                                 mst_addr, mst_rw, mst_data_wr);
                    end else begin
                        b  = exp_beat.pop_front();
                        nk = b.nack;
                        check("beat", {16'h0, mst_addr, mst_rw, (mst_rw ? 8'h00 : mst_data_wr)},
                              {16'h0, b.addr, b.rw, (b.rw ? 8'h00 : b.data)});
                    end
                    is_rd    = mst_rw;
                    mst_busy = 1'b1;
                    beats_seen++;
                    hi = $urandom_range(5, 9);
                    for (int i = 0; i < hi; i++) begin
                        @(posedge clk);
                        #1;
                        mst_ack_error = nk && i == 1;
                    end
                    mst_ack_error = 1'b0;
                    if (is_rd && slave_q.size() != 0)
                        mst_data_rd = slave_q.pop_front();
                    mst_busy = 1'b0;
                end
            end
        end
    end

    // Response monitor: compares each rsp pulse with the scoreboard and polices cmd_ready.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                check("rsp_pulse_width", {31'h0, prev_valid}, 32'h0);
                if (exp_rsp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: rdata %h err %b with nothing outstanding", rsp_rdata, rsp_err);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_r.rdata);
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, mon_r.err});
                end
                check("beats_left", exp_beat.size(), 32'h0);
                outstanding--;
            end else if (outstanding > 0) begin
                check("ready_while_busy", {31'h0, cmd_ready}, 32'h0);
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation limit reached with %0d outstanding", outstanding);
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int base;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_mst_ena", {31'h0, mst_ena}, 32'h0);
        check("rst_mst_bus", {16'h0, mst_addr, mst_rw, mst_data_wr}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(1'b0, 7'h48, 8'h01, 8'hA5, 2'd0, 1'b0, 32'h0);
        issue(1'b1, 7'h68, 8'h3B, 8'h00, 2'd1, 1'b0, 32'h0000_3412);
        issue(1'b1, 7'h50, 8'h10, 8'h00, 2'd3, 1'b0, 32'hEFBE_ADDE);
        issue(1'b0, 7'h22, 8'h05, 8'h77, 2'd0, 1'b1, 32'h0);
        for (int i = 0; i < 30; i++)
            issue(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                  $urandom_range(0, 3) == 0, $urandom);
        cmd_valid = 1'b0;

        n = 0;
        while (outstanding > 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("all_responded", outstanding, 32'h0);
        check("rsp_queue_empty", exp_rsp.size(), 32'h0);

        base = beats_seen;
        issue(1'b1, 7'h3C, 8'h20, 8'h00, 2'd3, 1'b0, 32'h1122_3344);
        cmd_valid = 1'b0;
        n = 0;
        while (beats_seen < base + 2 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_beat1", {31'h0, beats_seen >= base + 2}, 32'h1);
        check("ena_before_reset", {31'h0, mst_ena}, 32'h1);
        reset = 1'b1;
        exp_beat.delete();
        exp_rsp.delete();
        slave_q.delete();
        outstanding = 0;
        #1;
        check("mid_rst_mst_ena", {31'h0, mst_ena}, 32'h0);
        check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("mid_rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        finish_run();
    end

endmodule
